// File: rtl/aes_mixcol_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES MixColumns engine.
package aes_mixcol_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [31:0]  col_word_t;
  typedef logic [127:0] aes_block_t;

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mixcol_if.sv
// Input/output block handshake between the round datapath and the MixColumns engine.
interface aes_mixcol_if import aes_mixcol_pkg::*; ();

  // A transfer happens on a rising edge where valid and ready are both 1; once valid
  // is raised the producer holds its payload stable until that edge, and ready may
  // depend on the consumer's state but never combinationally on valid.
  logic       in_valid;
  logic       in_ready;
  aes_block_t din;
  logic       enc_dec;
  logic       bypass;
  logic       out_valid;
  logic       out_ready;
  aes_block_t dout;

  modport master (
    output in_valid, din, enc_dec, bypass, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, enc_dec, bypass, out_ready,
    output in_ready, out_valid, dout
  );

endinterface

// File: rtl/aes_mixcol_column.sv
// One-column MixColumns / InvMixColumns transform, purely combinational.
module aes_mixcol_column
  import aes_mixcol_pkg::*;
(
  input  col_word_t x,
  input  logic      enc_dec,
  input  logic      bypass,
  output col_word_t y
);

  logic [7:0] a   [4];
  logic [7:0] m2  [4];
  logic [7:0] m4  [4];
  logic [7:0] m8  [4];
  logic [7:0] fwd [4];
  logic [7:0] inv [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    localparam int J1 = (i + 1) % 4;
    localparam int J2 = (i + 2) % 4;
    localparam int J3 = (i + 3) % 4;

    assign a[i]  = x[31-8*i -: 8];
    assign m2[i] = xtime(a[i]);
    assign m4[i] = xtime(m2[i]);
    assign m8[i] = xtime(m4[i]);

    // 02*a_i ^ 03*a_i+1 ^ a_i+2 ^ a_i+3
    assign fwd[i] = m2[i] ^ m2[J1] ^ a[J1] ^ a[J2] ^ a[J3];
    // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
    assign inv[i] = (m8[i]  ^ m4[i]  ^ m2[i])
                  ^ (m8[J1] ^ m2[J1] ^ a[J1])
                  ^ (m8[J2] ^ m4[J2] ^ a[J2])
                  ^ (m8[J3] ^ a[J3]);
  end

  always_comb begin
    y = x;
    if (!bypass) begin
      if (enc_dec) y = {fwd[0], fwd[1], fwd[2], fwd[3]};
      else         y = {inv[0], inv[1], inv[2], inv[3]};
    end
  end

endmodule

// File: rtl/aes_mixcol_engine.sv
// Iterative MixColumns/InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per clock.
module aes_mixcol_engine
  import aes_mixcol_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         CLK,
  input  logic         RST,
  aes_mixcol_if.slave  bus,
  output logic         busy,
  output state_e       dbg_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Index of the first column of the final group; the step wraps to 0 when all four go at once.
  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);

  logic [1:0] state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  aes_block_t work_q, work_d;
  logic       enc_q, enc_d;
  logic       byp_q, byp_d;

  col_word_t  cur_col  [4];
  col_word_t  new_col  [4];
  logic [1:0] grp_idx  [COLS_PER_CYCLE];
  col_word_t  grp_in   [COLS_PER_CYCLE];
  col_word_t  grp_out  [COLS_PER_CYCLE];

  for (genvar c = 0; c < 4; c++) begin : g_view
    assign cur_col[c] = work_q[127-32*c -: 32];
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign grp_idx[g] = col_idx_q + 2'(g);
    assign grp_in[g]  = cur_col[grp_idx[g]];

    aes_mixcol_column u_col (
      .x       (grp_in[g]),
      .enc_dec (enc_q),
      .bypass  (byp_q),
      .y       (grp_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    work_d    = work_q;
    enc_d     = enc_q;
    byp_d     = byp_q;
    new_col   = cur_col;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          work_d    = bus.din;
          enc_d     = bus.enc_dec;
          byp_d     = bus.bypass;
          col_idx_d = 2'd0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          new_col[grp_idx[g]] = grp_out[g];
        end
        work_d    = {new_col[0], new_col[1], new_col[2], new_col[3]};
        col_idx_d = col_idx_q + STEP;
        if (col_idx_q == LAST_IDX) begin
          col_idx_d = 2'd0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        col_idx_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      col_idx_q <= 2'd0;
      work_q    <= '0;
      enc_q     <= 1'b0;
      byp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      work_q    <= work_d;
      enc_q     <= enc_d;
      byp_q     <= byp_d;
    end
  end

  // dout is masked outside DONE so a partially transformed state is never visible.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.dout      = (state_q == ST_DONE) ? work_q : '0;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_e'(state_q);

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Directed bench for aes_mixcol_engine with one instance per COLS_PER_CYCLE value (1, 2, 4).
module tb_aes_mixcol_engine;
  import aes_mixcol_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // index 0 -> COLS_PER_CYCLE=1, 1 -> 2, 2 -> 4
  logic         in_valid_a  [3];
  logic [127:0] din_a       [3];
  logic         enc_a       [3];
  logic         byp_a       [3];
  logic         out_ready_a [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic [127:0] dout_a      [3];
  logic         busy_a      [3];
  state_e       dbg_a       [3];

  aes_mixcol_if if_1 ();
  aes_mixcol_if if_2 ();
  aes_mixcol_if if_4 ();

  assign if_1.in_valid = in_valid_a[0];  assign if_1.din = din_a[0];
  assign if_1.enc_dec  = enc_a[0];       assign if_1.bypass = byp_a[0];
  assign if_1.out_ready = out_ready_a[0];
  assign in_ready_a[0] = if_1.in_ready;  assign out_valid_a[0] = if_1.out_valid;
  assign dout_a[0]     = if_1.dout;

  assign if_2.in_valid = in_valid_a[1];  assign if_2.din = din_a[1];
  assign if_2.enc_dec  = enc_a[1];       assign if_2.bypass = byp_a[1];
  assign if_2.out_ready = out_ready_a[1];
  assign in_ready_a[1] = if_2.in_ready;  assign out_valid_a[1] = if_2.out_valid;
  assign dout_a[1]     = if_2.dout;

  assign if_4.in_valid = in_valid_a[2];  assign if_4.din = din_a[2];
  assign if_4.enc_dec  = enc_a[2];       assign if_4.bypass = byp_a[2];
  assign if_4.out_ready = out_ready_a[2];
  assign in_ready_a[2] = if_4.in_ready;  assign out_valid_a[2] = if_4.out_valid;
  assign dout_a[2]     = if_4.dout;

  aes_mixcol_engine #(.COLS_PER_CYCLE(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .bus(if_1), .busy(busy_a[0]), .dbg_state(dbg_a[0]));
  aes_mixcol_engine #(.COLS_PER_CYCLE(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .bus(if_2), .busy(busy_a[1]), .dbg_state(dbg_a[1]));
  aes_mixcol_engine #(.COLS_PER_CYCLE(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .bus(if_4), .busy(busy_a[2]), .dbg_state(dbg_a[2]));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V_BYP   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] V_D4    = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
  localparam logic [127:0] V_D4_MC = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
  localparam logic [127:0] V_ISO   = 128'hc6c6c6c6_01010101_d4d4d4d5_2d26314c;
  localparam logic [127:0] V_ISO_MC= 128'hc6c6c6c6_01010101_d5d5d7d6_4d7ebdf8;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    for (int d = 0; d < 3; d++) begin
      in_valid_a[d]  = 1'b0;
      din_a[d]       = '0;
      enc_a[d]       = 1'b1;
      byp_a[d]       = 1'b0;
      out_ready_a[d] = 1'b1;
    end
  endtask

  // Offers one block, scrambles the side inputs after the accept edge, and returns
  // the accept-to-out_valid latency in cycles (-1 on timeout) plus the dout seen.
  task automatic run_block(input int d, input logic [127:0] blk, input logic enc,
                           input logic byp, output int lat, output logic [127:0] got);
    @(negedge CLK);
    in_valid_a[d] = 1'b1; din_a[d] = blk; enc_a[d] = enc; byp_a[d] = byp;
    @(negedge CLK);
    in_valid_a[d] = 1'b0; din_a[d] = ~blk; enc_a[d] = ~enc; byp_a[d] = ~byp;
    lat = -1;
    got = '0;
    for (int k = 1; k <= 20; k++) begin
      if (out_valid_a[d]) begin
        lat = k - 1;
        got = dout_a[d];
        break;
      end
      @(negedge CLK);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready_a[d] !== 1'b1 || out_valid_a[d] !== 1'b0 || busy_a[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_flags dut=%0d in_ready=%b out_valid=%b busy=%b exp 1/0/0",
                 d, in_ready_a[d], out_valid_a[d], busy_a[d]);
      end
      checks++;
      if (dout_a[d] !== 128'h0) begin
        failures++;
        $display("FAIL reset_dout dut=%0d got=%h exp=0", d, dout_a[d]);
      end
    end
    checks++;
    if (dbg_a[0] !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_a[0], IDLE);
    end
    RST = 1'b0;
  endtask

  task automatic test_forward();
    int lat;
    logic [127:0] got, exp_v;
    exp_q.push_back(V_MIXED);
    run_block(0, V_PLAIN, 1'b1, 1'b0, lat, got);
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL fwd_dout got=%h exp=%h", got, exp_v);
    end
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL fwd_latency got=%0d exp=4", lat);
    end
    @(negedge CLK);
    checks++;
    if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1) begin
      failures++;
      $display("FAIL fwd_one_cycle out_valid=%b in_ready=%b exp 0/1", out_valid_a[0], in_ready_a[0]);
    end
  endtask

  task automatic test_inverse();
    int lat;
    logic [127:0] got, exp_v;
    exp_q.push_back(V_PLAIN);
    run_block(2, V_MIXED, 1'b0, 1'b0, lat, got);
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL inv_dout got=%h exp=%h", got, exp_v);
    end
    checks++;
    if (lat !== 1) begin
      failures++; $display("FAIL inv_latency got=%0d exp=1", lat);
    end
  endtask

  task automatic test_bypass();
    int lat;
    logic [127:0] got, exp_v;
    exp_q.push_back(V_BYP);
    run_block(1, V_BYP, 1'b1, 1'b1, lat, got);
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL byp_dout got=%h exp=%h", got, exp_v);
    end
    checks++;
    if (lat !== 2) begin
      failures++; $display("FAIL byp_latency got=%0d exp=2", lat);
    end
  endtask

  task automatic test_cols_mix();
    int lat;
    logic [127:0] got, exp_v;
    exp_q.push_back(V_PLAIN);
    run_block(0, V_MIXED, 1'b0, 1'b0, lat, got);
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || lat !== 4) begin
      failures++; $display("FAIL inv_c1 got=%h lat=%0d exp=%h lat=4", got, lat, exp_v);
    end
    exp_q.push_back(V_ISO_MC);
    run_block(1, V_ISO, 1'b1, 1'b0, lat, got);
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || lat !== 2) begin
      failures++; $display("FAIL fwd_c2 got=%h lat=%0d exp=%h lat=2", got, lat, exp_v);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] got, exp_v;
    out_ready_a[0] = 1'b0;
    exp_q.push_back(V_MIXED);
    run_block(0, V_PLAIN, 1'b1, 1'b0, lat, got);
    exp_v = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid_a[0] !== 1'b1 || dout_a[0] !== exp_v || in_ready_a[0] !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold c=%0d out_valid=%b in_ready=%b dout=%h exp 1/0/%h",
                 c, out_valid_a[0], in_ready_a[0], dout_a[0], exp_v);
      end
      if (c == 1) begin
        in_valid_a[0] = 1'b1; din_a[0] = V_BYP;
      end
      if (c == 2) in_valid_a[0] = 1'b0;
      @(negedge CLK);
    end
    checks++;
    if (dout_a[0] !== exp_v) begin
      failures++; $display("FAIL bp_final_dout got=%h exp=%h", dout_a[0], exp_v);
    end
    out_ready_a[0] = 1'b1;
    @(negedge CLK);
    checks++;
    if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp 0/1/0",
               out_valid_a[0], in_ready_a[0], busy_a[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [127:0] got, exp_v;
    @(negedge CLK);
    in_valid_a[0] = 1'b1; din_a[0] = V_PLAIN; enc_a[0] = 1'b1; byp_a[0] = 1'b0;
    @(negedge CLK);
    in_valid_a[0] = 1'b0;
    checks++;
    if (busy_a[0] !== 1'b1) begin
      failures++; $display("FAIL rst_run_busy got=%b exp=1", busy_a[0]);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0 ||
        dout_a[0] !== 128'h0) begin
      failures++;
      $display("FAIL rst_mid in_ready=%b out_valid=%b busy=%b dout=%h exp 1/0/0/0",
               in_ready_a[0], out_valid_a[0], busy_a[0], dout_a[0]);
    end
    exp_q.push_back(V_D4_MC);
    run_block(0, V_D4, 1'b1, 1'b0, lat, got);
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || lat !== 4) begin
      failures++; $display("FAIL rst_after_block got=%h lat=%0d exp=%h lat=4", got, lat, exp_v);
    end
  endtask

  task automatic test_isolation();
    int lat;
    logic [127:0] got, exp_v;
    exp_q.push_back(V_ISO_MC);
    run_block(0, V_ISO, 1'b1, 1'b0, lat, got);
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL iso_dout got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    @(negedge CLK);
    in_valid_a[2] = 1'b1; din_a[2] = V_PLAIN; enc_a[2] = 1'b1; byp_a[2] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      checks++;
      if (out_valid_a[2] === 1'b1 && in_ready_a[2] === 1'b1) begin
        failures++; $display("FAIL b2b_exclusive k=%0d out_valid=1 in_ready=1 exp not both", k);
      end
      if (out_valid_a[2] === 1'b1) begin
        pulses++;
        checks++;
        if (dout_a[2] !== V_MIXED) begin
          failures++; $display("FAIL b2b_dout k=%0d got=%h exp=%h", k, dout_a[2], V_MIXED);
        end
      end
    end
    in_valid_a[2] = 1'b0;
    checks++;
    if (pulses !== 3) begin
      failures++; $display("FAIL b2b_throughput got=%0d exp=3", pulses);
    end
    repeat (2) @(negedge CLK);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_forward();
    test_inverse();
    test_bypass();
    test_cols_mix();
    test_backpressure();
    test_reset_mid_run();
    test_isolation();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_mixcol_engine.md
Name: aes_mixcol_engine

Overview:
- Iterative AES MixColumns/InvMixColumns unit for a full 128-bit state.
- Processes COLS_PER_CYCLE 32-bit columns per clock.
- Uses a valid/ready handshake on input and output, a per-block direction select, and a bypass for the final round.
- Sits between ShiftRows and AddRoundKey in the round datapath; replaces the single-column combinational MixColumns where the area/throughput trade-off must be tunable.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  din/enc_dec/bypass valid.
- in_ready  output  1  engine can accept a block.
- din  input  128  state; column c = din[127-32c -: 32]; within a column, bits [31:24] hold row 0.
- enc_dec  input  1  1 = MixColumns (encrypt), 0 = InvMixColumns (decrypt).
- bypass  input  1  1 = output equals input (final round); latency unchanged.
- out_valid  output  1  dout valid.
- out_ready  input  1  downstream accepts dout.
- dout  output  128  transformed state, same column/row packing as din.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: on RST=1 at a clock edge:
  - state goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, dout=0, column counter=0, working register=0.
  - Reset mid-RUN or mid-DONE discards the block; no partial output is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 loads din into the working register, latches enc_dec and bypass, clears col_idx, and goes to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, columns col_idx .. col_idx+COLS_PER_CYCLE-1 are replaced in the working register by their transform.
  - col_idx advances by COLS_PER_CYCLE.
  - When the last group (columns ending at 3) is written, go to DONE.
  - RUN length is 4/COLS_PER_CYCLE cycles: 4, 2 or 1.
- DONE:
  - out_valid=1 and dout = working register, held stable until out_ready=1.
  - On out_ready=1, go to IDLE; out_valid drops on the next cycle.
  - in_ready stays 0 in DONE. No accept-while-draining: throughput is one block per 4/COLS_PER_CYCLE+2 cycles with out_ready tied high.
- Latency: the accept edge to the first cycle with out_valid=1 is 4/COLS_PER_CYCLE cycles.
- in_valid and din are ignored outside IDLE. enc_dec and bypass may change freely after accept without effect.
- Column transform, GF(2^8) with polynomial x^8+x^4+x^3+x+1:
  - Forward matrix rows: {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
  - Inverse matrix rows: {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
  - Bypass: the column is passed through unchanged.
- The inverse is built from xtime chains, with no multiplier tables. The transform is purely combinational, one column wide, and instantiated COLS_PER_CYCLE times.
- Counter wrap: col_idx is 2 bits. It wraps to 0 on the DONE transition and never indexes beyond column 3.
- out_valid and in_ready are never both 1.

Decomposition:
- Package aes_mixcol_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - AES reduction constant 8'h1B;
  - a column word type (32 bits);
  - the xtime function.
- Sub-module aes_mixcol_column:
  - ports: 32-bit x, enc_dec, bypass in; 32-bit y out;
  - combinational; row-0 byte in [31:24].
- The top level holds the FSM, the counter, the working register and the handshake.

Test Plan:
- Forward: COLS_PER_CYCLE=1, enc_dec=1, din=db135345_f20a225c_01010101_2d26314c, out_ready=1.
  - Required: dout=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
  - out_valid asserts 4 cycles after accept and stays high exactly 1 cycle.
- Inverse: COLS_PER_CYCLE=4, enc_dec=0, din=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
  - Required: dout=db135345_f20a225c_01010101_2d26314c, 1-cycle latency.
- Bypass: COLS_PER_CYCLE=2, bypass=1, din=00112233_44556677_8899aabb_ccddeeff.
  - Required: dout equals din; out_valid 2 cycles after accept.
- Backpressure: out_ready=0 for 5 cycles in DONE.
  - Required: dout and out_valid stay stable, and in_ready=0 throughout.
  - A new in_valid pulse during that time is not accepted.
  - Raising out_ready returns the engine to IDLE, with in_ready=1 on the next cycle.
- Reset mid-RUN: assert RST on the 2nd RUN cycle (COLS_PER_CYCLE=1).
  - Required: next cycle in_ready=1, out_valid=0, busy=0, dout=0.
  - A following block (d4d4d4d5 in all columns, forward) gives d5d5d7d6 in all columns.
- Per-column isolation: COLS_PER_CYCLE=1, forward, din=c6c6c6c6_01010101_d4d4d4d5_2d26314c.
  - Required: dout=c6c6c6c6_01010101_d5d5d7d6_4d7ebdf8.
